lu_sequencer: RTL and testbench

Instruction fetch/decode sequencer for the 1-bit control unit. It fetches 8-bit instructions from program memory over a req/ack handshake and decodes them into the logic unit's 3-bit opcode and A operand. It observes the logic unit's result register, drives 1-bit output-port writes, and handles skip, jump and halt flow control. It is the initiator that drives the logic unit, which executes whatever opcode it receives every clock.

---
 rtl/lu_sequencer.sv | 128 ++++++++++++
 tb/tb_lu_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lu_sequencer.sv
// Instruction fetch/decode sequencer for the 1-bit logic unit: fetches bytes over
// req/ack, decodes LU ops, output-port stores, skip/jump/halt flow control.
module lu_sequencer #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [7:0]        mem_data,
    input  logic [7:0]        data_in,
    input  logic              rr,
    output logic [2:0]        luop,
    output logic              lu_a,
    output logic              lu_b,
    output logic              out_we,
    output logic [2:0]        out_sel,
    output logic              out_data,
    output logic              halt,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_EXEC   = 2'd1,
        S_FETCH2 = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    localparam logic [3:0] OP_STO  = 4'h8;
    localparam logic [3:0] OP_STOC = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_SKZ  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hD;
    localparam logic [3:0] OP_JZ   = 4'hE;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        ir_q, ir_d;
    logic              skip_q, skip_d;
    logic              taken_q, taken_d;

    logic [3:0] opcode;
    logic [3:0] operand;
    logic       is_branch;
    logic       exec_live;
    logic       lu_live;

    assign opcode    = ir_q[7:4];
    assign operand   = ir_q[3:0];
    assign is_branch = (opcode == OP_JMP) || (opcode == OP_JZ);

    // Handshake: a transfer completes on a rising edge where mem_req and mem_ack
    // are both high; mem_req/mem_addr hold until then, ack without req is ignored.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        skip_d  = skip_q;
        taken_d = taken_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ack) begin
                    ir_d    = mem_data;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                taken_d = 1'b0;
                if (skip_q) begin
                    // A skipped branch still consumes its operand byte.
                    skip_d = 1'b0;
                    if (is_branch) state_d = S_FETCH2;
                end else begin
                    case (opcode)
                        OP_SKZ:  if (!rr) skip_d = 1'b1;
                        OP_JMP:  begin taken_d = 1'b1; state_d = S_FETCH2; end
                        OP_JZ:   begin taken_d = !rr;  state_d = S_FETCH2; end
                        OP_HALT: state_d = S_HALT;
                        default: ;
                    endcase
                end
            end
            S_FETCH2: begin
                if (mem_ack) begin
                    pc_d    = taken_q ? ADDR_W'(mem_data) : pc_q + ADDR_W'(1);
                    state_d = S_FETCH;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            skip_q  <= 1'b0;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            skip_q  <= skip_d;
            taken_q <= taken_d;
        end
    end

    // The LU has no enable, so outside a live LU op it is fed load-of-rr to hold Y.
    assign exec_live = (state_q == S_EXEC) && !rst && !skip_q;
    assign lu_live   = exec_live && !opcode[3];

    assign luop     = rst ? 3'b000 : (lu_live ? opcode[2:0] : 3'b001);
    assign lu_a     = rst ? 1'b0 : (lu_live ? (operand[3] | data_in[operand[2:0]]) : rr);
    assign lu_b     = rst ? 1'b0 : rr;
    assign out_we   = exec_live && ((opcode == OP_STO) || (opcode == OP_STOC));
    assign out_sel  = out_we ? operand[2:0] : 3'b000;
    assign out_data = out_we ? (rr ^ opcode[0]) : 1'b0;
    assign mem_req  = !rst && ((state_q == S_FETCH) || (state_q == S_FETCH2));
    assign mem_addr = rst ? '0 : pc_q;
    assign halt     = !rst && (state_q == S_HALT);
    assign dbg_state = rst ? 2'd0 : state_q;

endmodule

// File: tb/tb_lu_sequencer.sv
// Directed bench for lu_sequencer: byte memory with programmable ack delay,
// a small logic-unit model closing the rr loop, and an output-write scoreboard.
module tb_lu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] mem_addr;
    logic       mem_req;
    logic       mem_ack;
    logic [7:0] mem_data;
    logic [7:0] data_in;
    logic       rr;
    logic [2:0] luop;
    logic       lu_a;
    logic       lu_b;
    logic       out_we;
    logic [2:0] out_sel;
    logic       out_data;
    logic       halt;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mem [256];
    int         ack_delay = 0;
    int         wait_cnt  = 0;
    logic       lu_y      = 1'b1;

    logic [3:0] wr_q[$];
    logic [3:0] exp_q[$];

    lu_sequencer #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_data(mem_data),
        .data_in(data_in), .rr(rr),
        .luop(luop), .lu_a(lu_a), .lu_b(lu_b),
        .out_we(out_we), .out_sel(out_sel), .out_data(out_data),
        .halt(halt), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    assign mem_data = mem[mem_addr];
    assign mem_ack  = mem_req && (wait_cnt >= ack_delay);
    assign rr       = lu_y;

    always @(posedge clk) begin
        if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
        else                     wait_cnt <= 0;
    end

    // Logic unit model: executes whatever opcode is presented every clock.
    always @(posedge clk) begin
        case (luop)
            3'b000:  lu_y <= 1'b0;
            3'b001:  lu_y <= lu_a;
            3'b010:  lu_y <= lu_a & lu_b;
            3'b011:  lu_y <= lu_a | lu_b;
            3'b100:  lu_y <= lu_a ^ lu_b;
            default: lu_y <= lu_y;
        endcase
    end

    always @(posedge clk) begin
        if (!rst && out_we) wr_q.push_back({out_sel, out_data});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'hC0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wr_q.delete();
        exp_q.delete();
        #1;
    endtask

    task automatic compare_writes(input string tag);
        check({tag, "_count"}, wr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < wr_q.size()) check({tag, "_write"}, wr_q[i], exp_q[i]);
        end
    endtask

    initial begin
        rst     = 1'b1;
        data_in = 8'h00;
        clear_mem();

        // Reset clear
        @(negedge clk); #1;
        check("rst_luop", luop, 3'b000);
        check("rst_lu_a", lu_a, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_out_we", out_we, 1'b0);
        check("rst_halt", halt, 1'b0);
        @(negedge clk);
        rst = 1'b0; #1;
        check("rel_mem_req", mem_req, 1'b1);
        check("rel_mem_addr", mem_addr, 8'h00);
        check("rel_halt", halt, 1'b0);
        check("rel_out_we", out_we, 1'b0);

        // LU op then store
        clear_mem();
        mem[0] = 8'h13; mem[1] = 8'h85; mem[2] = 8'hD0;
        data_in = 8'h08;
        do_reset();
        cyc(1);
        check("lu_luop", luop, 3'b001);
        check("lu_lu_a", lu_a, 1'b1);
        cyc(1);
        check("lu_rr", rr, 1'b1);
        check("lu_b_eq_rr", lu_b, 1'b1);
        check("lu_fetch_we", out_we, 1'b0);
        cyc(1);
        check("sto_we", out_we, 1'b1);
        check("sto_sel", out_sel, 3'd5);
        check("sto_data", out_data, 1'b1);
        data_in = 8'h00;

        // Skip taken (rr=0)
        clear_mem();
        mem[0] = 8'h00; mem[1] = 8'hB0; mem[2] = 8'h82; mem[3] = 8'h93; mem[4] = 8'hD0;
        do_reset();
        exp_q.push_back({3'd3, 1'b1});
        cyc(14);
        compare_writes("skz_rr0");
        check("skz_halt", halt, 1'b1);
        check("skz_halt_req", mem_req, 1'b0);

        // Skip not taken (rr=1)
        clear_mem();
        mem[0] = 8'h18; mem[1] = 8'hB0; mem[2] = 8'h82; mem[3] = 8'h93; mem[4] = 8'hD0;
        do_reset();
        exp_q.push_back({3'd2, 1'b1});
        exp_q.push_back({3'd3, 1'b0});
        cyc(14);
        compare_writes("skz_rr1");

        // JMP
        clear_mem();
        mem[0] = 8'hA0; mem[1] = 8'h40; mem[8'h40] = 8'hD0;
        do_reset();
        cyc(2);
        check("jmp_op_addr", mem_addr, 8'h01);
        check("jmp_op_req", mem_req, 1'b1);
        check("jmp_f2_luop", luop, 3'b001);
        check("jmp_f2_lu_a", lu_a, rr);
        cyc(1);
        check("jmp_target", mem_addr, 8'h40);

        // JZ not taken with rr=1
        clear_mem();
        mem[0] = 8'h18; mem[1] = 8'hE0; mem[2] = 8'h40; mem[3] = 8'h82; mem[4] = 8'hD0;
        mem[8'h40] = 8'h87;
        do_reset();
        exp_q.push_back({3'd2, 1'b1});
        cyc(5);
        check("jz_fall_addr", mem_addr, 8'h03);
        cyc(10);
        compare_writes("jz_fall");

        // JZ taken with rr=0
        clear_mem();
        mem[0] = 8'h00; mem[1] = 8'hE0; mem[2] = 8'h40; mem[8'h40] = 8'hD0;
        do_reset();
        cyc(5);
        check("jz_taken_addr", mem_addr, 8'h40);

        // SKZ skips a JMP: operand consumed, no branch
        clear_mem();
        mem[0] = 8'h00; mem[1] = 8'hB0; mem[2] = 8'hA0; mem[3] = 8'h40; mem[4] = 8'h84;
        mem[5] = 8'hD0; mem[8'h40] = 8'h87;
        do_reset();
        exp_q.push_back({3'd4, 1'b0});
        cyc(6);
        check("skjmp_op_addr", mem_addr, 8'h03);
        cyc(1);
        check("skjmp_next_addr", mem_addr, 8'h04);
        cyc(10);
        compare_writes("skjmp");

        // Wait states: three-cycle ack delay
        clear_mem();
        mem[0] = 8'h18; mem[1] = 8'hD0;
        ack_delay = 3;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            check("ws_req", mem_req, 1'b1);
            check("ws_addr", mem_addr, 8'h00);
            check("ws_luop", luop, 3'b001);
            check("ws_lu_a", lu_a, 1'b0);
            cyc(1);
        end
        check("ws_exec_req", mem_req, 1'b0);
        check("ws_exec_lu_a", lu_a, 1'b1);
        ack_delay = 0;

        // PC wrap after a NOP at 0xFF
        clear_mem();
        mem[0] = 8'hA0; mem[1] = 8'hFF; mem[8'hFF] = 8'hC0;
        do_reset();
        cyc(3);
        check("wrap_fetch_ff", mem_addr, 8'hFF);
        cyc(2);
        check("wrap_addr", mem_addr, 8'h00);

        // HALT
        clear_mem();
        mem[0] = 8'hD0;
        do_reset();
        cyc(2);
        check("halt_flag", halt, 1'b1);
        check("halt_state", dbg_state, 2'd3);
        cyc(20);
        check("halt_stays", halt, 1'b1);
        check("halt_no_req", mem_req, 1'b0);
        check("halt_luop", luop, 3'b001);

        // Reset during a STO EXEC: no write strobe in the reset cycle
        clear_mem();
        mem[0] = 8'h85;
        do_reset();
        cyc(1);
        check("sto_pre_rst_we", out_we, 1'b1);
        rst = 1'b1; #1;
        check("sto_rst_we", out_we, 1'b0);
        check("sto_rst_luop", luop, 3'b000);
        @(negedge clk);
        rst = 1'b0; #1;
        check("sto_rst_writes", wr_q.size(), 0);

        // Reset during a FETCH2 wait abandons the branch
        clear_mem();
        mem[0] = 8'hA0; mem[1] = 8'h40; mem[8'h40] = 8'h87;
        ack_delay = 3;
        do_reset();
        cyc(5);
        check("f2w_addr", mem_addr, 8'h01);
        cyc(1);
        check("f2w_req", mem_req, 1'b1);
        rst = 1'b1; #1;
        check("f2w_rst_req", mem_req, 1'b0);
        @(negedge clk);
        rst = 1'b0; #1;
        check("f2w_pc0", mem_addr, 8'h00);
        check("f2w_req_after", mem_req, 1'b1);
        ack_delay = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
